// File: rtl/interval_arbiter_if.sv
// Bundle between the requesting control FSMs (master) and the interval arbiter (slave).
// Slice i of len belongs to requester i.
interface interval_arbiter_if #(
  parameter int N = 7
);
  logic [3:0]     req;
  logic [4*N-1:0] len;
  logic           abort;
  logic [3:0]     gnt;
  logic [1:0]     id;
  logic           busy;
  logic [N-1:0]   q;
  logic [3:0]     done;

  modport master (
    output req, len, abort,
    input  gnt, id, busy, q, done
  );

  modport slave (
    input  req, len, abort,
    output gnt, id, busy, q, done
  );
endinterface

// File: rtl/interval_arbiter.sv
// Round-robin arbiter that lends one shared N-bit interval counter to four requesters.
// A granted run lasts len+1 cycles and ends with a one-cycle done pulse, unless it is aborted.
module interval_arbiter #(
  parameter int N = 7
) (
  input  logic              clk,
  input  logic              rst,
  interval_arbiter_if.slave bus
);
  localparam int NREQ = 4;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [1:0]      id_q, id_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    limit_q, limit_d;

  logic [N-1:0]    len_arr [NREQ];
  logic [NREQ-1:0] rot_req;
  logic [1:0]      win;
  logic            any_req;
  logic [1:0]      next_ptr;

  // rot_req[k] is the request of index ptr+k, so bit 0 always has top priority
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      logic [1:0] rot_idx;
      assign rot_idx     = ptr_q + 2'(gi);
      assign len_arr[gi] = bus.len[gi*N +: N];
      assign rot_req[gi] = bus.req[rot_idx];
    end
  endgenerate

  always_comb begin
    any_req = |rot_req;
    win     = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win = ptr_q + 2'(k);
      end
    end
  end

  assign next_ptr = id_q + 2'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    id_d    = id_q;
    q_d     = q_q;
    limit_d = limit_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        q_d   = '0;
        if (any_req) begin
          state_d    = ST_RUN;
          gnt_d[win] = 1'b1;
          id_d       = win;
          limit_d    = len_arr[win];
        end
      end
      ST_RUN: begin
        // abort wins over a run that would complete on the same edge
        if (bus.abort) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          q_d     = '0;
          ptr_d   = next_ptr;
        end else if (q_q == limit_q) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          q_d     = '0;
          done_d  = gnt_q;
          ptr_d   = next_ptr;
        end else begin
          q_d = q_q + N'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        q_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      id_q    <= '0;
      q_q     <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      id_q    <= id_d;
      q_q     <= q_d;
      limit_q <= limit_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.id   = id_q;
  assign bus.q    = q_q;
  assign bus.busy = |gnt_q;
endmodule
